// File: rtl/execute_issue_ctrl.sv
// execute_issue_ctrl: 2-entry in-order issue buffer feeding Execute, holding
// multi-cycle instructions for MULTI_LAT cycles and discarding work on flush.
module execute_issue_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32,
    parameter int MULTI_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-3:0] in_addr,
    input  logic [INSN_WIDTH-1:0] in_insn,
    input  logic                  in_multi,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [ADDR_WIDTH-3:0] ex_addr,
    output logic [INSN_WIDTH-1:0] ex_insn,
    output logic                  ex_first,
    output logic                  ex_busy,
    output logic [1:0]            occupancy
);
    typedef enum logic {IDLE, MULTI} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MULTI_LAT - 1);

    logic [ADDR_WIDTH-3:0] r_addr [2];
    logic [INSN_WIDTH-1:0] r_insn [2];
    logic [1:0]            r_multi;
    logic                  r_wp;
    logic                  r_rp;
    logic [1:0]            r_count;
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  w_pop;
    logic                  w_push;

    assign ex_valid  = r_count != 2'd0;
    assign ex_addr   = r_addr[r_rp];
    assign ex_insn   = r_insn[r_rp];
    assign ex_first  = ex_valid && r_state == IDLE;
    assign ex_busy   = r_state == MULTI;
    assign occupancy = r_count;

    // A head leaves after one cycle, or after the counter reaches the last cycle of a multi.
    assign w_pop    = !flush && ex_valid && (r_state == IDLE ? !r_multi[r_rp] : r_cnt == LAT_M1);
    assign in_ready = !flush && (r_count != 2'd2 || w_pop);
    assign w_push   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                r_addr[k] <= '0;
                r_insn[k] <= '0;
            end
            r_multi <= '0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else if (flush) begin
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_count <= 2'd0;
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            if (w_push) begin
                r_addr[r_wp]  <= in_addr;
                r_insn[r_wp]  <= in_insn;
                r_multi[r_wp] <= in_multi;
                r_wp          <= !r_wp;
            end
            if (w_pop)
                r_rp <= !r_rp;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (r_state == IDLE && ex_valid && r_multi[r_rp]) begin
                r_state <= MULTI;
                r_cnt   <= 4'd1;
            end else if (r_state == MULTI) begin
                r_state <= r_cnt == LAT_M1 ? IDLE : MULTI;
                r_cnt   <= r_cnt == LAT_M1 ? 4'd0 : r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_execute_issue_ctrl.sv
// tb_execute_issue_ctrl: directed and random stimulus checked against a queue
// model tracking how many cycles the head instruction has been presented.
module tb_execute_issue_ctrl;
    localparam int ADDR_WIDTH = 32;
    localparam int INSN_WIDTH = 32;
    localparam int MULTI_LAT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_addr = '0;
    logic [31:0] in_insn = '0;
    logic        in_multi = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [29:0] ex_addr;
    logic [31:0] ex_insn;
    logic        ex_first;
    logic        ex_busy;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] i;
        bit          m;
    } ent_t;

    ent_t q[$];
    int   age = 0;

    always #5 clk = ~clk;

    execute_issue_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .INSN_WIDTH(INSN_WIDTH), .MULTI_LAT(MULTI_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_insn(in_insn), .in_multi(in_multi), .flush(flush), .ex_valid(ex_valid),
        .ex_addr(ex_addr), .ex_insn(ex_insn), .ex_first(ex_first), .ex_busy(ex_busy),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare against the model before the edge, then advance the model.
    task automatic step(input bit v, input logic [29:0] a, input logic [31:0] ins, input bit m, input bit f);
        bit e_valid, pop, rdy;
        int lat;
        @(negedge clk);
        in_valid = v; in_addr = a; in_insn = ins; in_multi = m; flush = f;
        #1;
        e_valid = q.size() != 0;
        lat = (e_valid && q[0].m) ? MULTI_LAT : 1;
        pop = e_valid && !f && age == lat - 1;
        rdy = !f && (q.size() < 2 || pop);
        chk("ex_valid", 64'(ex_valid), 64'(e_valid));
        if (e_valid) begin
            chk("ex_addr", 64'(ex_addr), 64'(q[0].a));
            chk("ex_insn", 64'(ex_insn), 64'(q[0].i));
        end
        chk("ex_first", 64'(ex_first), 64'(e_valid && age == 0));
        chk("ex_busy", 64'(ex_busy), 64'(age > 0));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        if (f) begin
            q.delete();
            age = 0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                age = 0;
            end else if (e_valid) age++;
            if (v && rdy) q.push_back('{a: a, i: ins, m: m});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, '0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_ex_addr", 64'(ex_addr), 64'd0);
        chk("rst_ex_insn", 64'(ex_insn), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        idle(1);
        // three back-to-back single-cycle instructions
        step(1, 30'h10, 32'h1000_0010, 0, 0);
        step(1, 30'h11, 32'h1000_0011, 0, 0);
        step(1, 30'h12, 32'h1000_0012, 0, 0);
        idle(3);
        // multi followed by a single
        step(1, 30'h20, 32'hAAAA_0001, 1, 0);
        step(1, 30'h21, 32'h0000_0013, 0, 0);
        idle(6);
        // fill the buffer while a multi is executing
        step(1, 30'h30, 32'hBBBB_0001, 1, 0);
        for (int k = 0; k < 6; k++) step(1, 30'(32'h31 + k), 32'(32'hC000_0000 + k), 0, 0);
        idle(6);
        // flush in cycle 2 of a multi with one entry queued and a push offered
        step(1, 30'h40, 32'hDDDD_0001, 1, 0);
        step(1, 30'h41, 32'hDDDD_0002, 0, 0);
        step(1, 30'h42, 32'hDDDD_0003, 0, 1);
        idle(2);
        // asynchronous reset with two entries buffered
        step(1, 30'h50, 32'hEEEE_0001, 1, 0);
        step(1, 30'h51, 32'hEEEE_0002, 1, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_ex_valid", 64'(ex_valid), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_ex_busy", 64'(ex_busy), 64'd0);
        chk("arst_ex_first", 64'(ex_first), 64'd0);
        chk("arst_ex_addr", 64'(ex_addr), 64'd0);
        chk("arst_ex_insn", 64'(ex_insn), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        age = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        for (int k = 0; k < 10000; k++)
            step($urandom_range(0, 9) < 6, 30'($urandom), $urandom, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0);
        idle(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/execute_issue_ctrl.md
Name: execute_issue_ctrl

Overview:
- Sequences instructions from Decode into the Execute stage.
- Holds up to 2 instructions in an in-order issue buffer.
- Presents one instruction at a time on the Execute inputs (valid/addr/insn), holding multi-cycle instructions for a fixed number of cycles.
- Discards all buffered or in-flight work on a pipeline flush (branch redirect).

Parameters:
- ADDR_WIDTH, 32: byte address width; instruction addresses carried as [ADDR_WIDTH-1:2] (4-byte aligned).
- INSN_WIDTH, 32: instruction word width.
- MULTI_LAT, 4: Execute occupancy in cycles of a multi-cycle instruction; legal range 2..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  Decode offers an instruction.
- in_ready  out  1  buffer accepts this cycle.
- in_addr  in  ADDR_WIDTH-2  instruction address [ADDR_WIDTH-1:2].
- in_insn  in  INSN_WIDTH  instruction word.
- in_multi  in  1  instruction needs MULTI_LAT Execute cycles.
- flush  in  1  discard everything, synchronous to clk.
- ex_valid  out  1  to Execute insn_valid.
- ex_addr  out  ADDR_WIDTH-2  to Execute insn_addr.
- ex_insn  out  INSN_WIDTH  to Execute insn.
- ex_first  out  1  first Execute cycle of the presented instruction.
- ex_busy  out  1  multi-cycle instruction in progress beyond its first cycle.
- occupancy  out  2  buffered entries, 0..2.

Behaviour:

Clock and reset:
- Single clock domain. rst is asynchronous, active-high.

Reset values:
- Buffer empty, occupancy=0.
- ex_valid=0, ex_first=0, ex_busy=0, in_ready=1.
- FSM in IDLE, cycle counter cnt=0.
- ex_addr and ex_insn are 0.

Buffer:
- 2-entry FIFO of {addr, insn, multi}, with 1-bit read and write pointers that wrap modulo 2 plus a 2-bit count.
- push = in_valid && in_ready.
- in_ready = !flush && (count<2 || pop). Push into a full buffer is allowed in the same cycle as a pop.
- Simultaneous push and pop: count unchanged, both pointers advance.

Presentation:
- ex_valid = (count!=0). ex_addr, ex_insn and the multi flag come from the head entry.
- All ex_* outputs are functions of registered state only; no combinational path from in_* to ex_*.
- Minimum latency: an instruction pushed into an empty buffer in cycle N appears on ex_* in cycle N+1.

FSM (states IDLE, MULTI; counter cnt is 4 bits):
- IDLE, head not multi:
  - pop = ex_valid.
  - Instruction is presented for exactly 1 cycle.
- IDLE, head multi, ex_valid=1:
  - No pop.
  - Next state MULTI, cnt<=1.
- MULTI:
  - cnt<=cnt+1.
  - When cnt==MULTI_LAT-1: pop=1, next state IDLE, cnt<=0.
  - A multi instruction is therefore presented for exactly MULTI_LAT consecutive cycles with stable ex_addr/ex_insn.
- ex_first = ex_valid && state==IDLE.
- ex_busy = (state==MULTI).
- Back-to-back issue: the next entry is presented in the cycle after a pop, with no bubble.

Flush:
- Effective at the next clk edge:
  - count<=0 and pointers<=0.
  - state<=IDLE, cnt<=0.
- During the flush cycle, in_ready=0 and in_valid is ignored (no push).
- pop is suppressed during the flush cycle.
- Flush in the middle of a multi-cycle instruction aborts it; ex_valid=0 in the next cycle.

Reset mid-operation:
- Same end state as the reset values, asynchronously.

Occupancy:
- occupancy equals count.

Test Plan:
- Reset, then 3 single-cycle pushes at addrs 0x10, 0x11, 0x12 on consecutive cycles -> ex_valid=1 for 3 consecutive cycles starting 1 cycle after the first push, addrs in order, ex_first=1 every cycle, occupancy never exceeds 2.
- Push multi insn 0xAAAA0001 then single 0x00000013 with MULTI_LAT=4 -> 0xAAAA0001 held 4 cycles (ex_first=1 only in cycle 1, ex_busy=1 in cycles 2-4), then 0x00000013 for 1 cycle in cycle 5.
- Fill buffer during a multi instruction -> in_ready=0 until the pop cycle; in the pop cycle in_ready=1 and the push is accepted, occupancy stays 2.
- flush asserted in cycle 2 of a multi instruction with 1 entry queued and in_valid=1 -> next cycle ex_valid=0, occupancy=0, ex_busy=0, pushed instruction not stored.
- rst asserted asynchronously mid-cycle with occupancy=2 -> all outputs go to reset values immediately, without waiting for a clk edge.
- Random in_valid/in_multi/flush, 10k cycles, against a scoreboard model -> order preserved, presented cycles = 1 or MULTI_LAT per instruction, no lost or duplicated instructions.
